// File: rtl/lowmc_ctrl_pkg.sv
// rtl/lowmc_ctrl_pkg.sv - shared constants and controller state type for the LowMC key controller
package lowmc_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam int DEF_N  = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CAPTURE
  } ctrl_state_t;

  function automatic int words_of(input int n);
    return n / WORD_W;
  endfunction

  // Never return a zero-width address, even for a single-word vector.
  function automatic int addr_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int WORDS = words_of(DEF_N);
  localparam int WR_AW = addr_w(2 * WORDS);
  localparam int RD_AW = addr_w(WORDS);

endpackage

// File: rtl/lowmc_key_ctrl_if.sv
// rtl/lowmc_key_ctrl_if.sv - controller-to-LowMC-core job handshake
interface lowmc_key_ctrl_if #(
  parameter int N = 128
);

  logic [N-1:0] CoreKey_DO;
  logic [N-1:0] CorePlain_DO;
  logic         CoreStart_SO;
  logic         CoreFinish_SI;
  logic [N-1:0] CoreCipher_DI;

  modport master (
    output CoreKey_DO,
    output CorePlain_DO,
    output CoreStart_SO,
    input  CoreFinish_SI,
    input  CoreCipher_DI
  );

  modport slave (
    input  CoreKey_DO,
    input  CorePlain_DO,
    input  CoreStart_SO,
    output CoreFinish_SI,
    output CoreCipher_DI
  );

endinterface

// File: rtl/lowmc_word_regfile.sv
// rtl/lowmc_word_regfile.sv - 32-bit word register file with valid mask, full-vector load and registered read
module lowmc_word_regfile
  import lowmc_ctrl_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic                    ld_en,
  input  logic [WORDS*WORD_W-1:0] ld_data,
  input  logic                    clr_valid,
  input  logic [AW-1:0]           rd_addr,
  output logic [WORDS*WORD_W-1:0] data_o,
  output logic [WORDS-1:0]        valid_o,
  output logic [WORD_W-1:0]       rd_data_o
);

  logic [WORDS*WORD_W-1:0] data_q, data_d;
  logic [WORDS-1:0]        valid_q, valid_d;
  logic [WORD_W-1:0]       rd_data_q, rd_data_d;

  // A clear suppresses any write in the same cycle; data words are never cleared.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    rd_data_d = '0;
    if (clr_valid) begin
      valid_d = '0;
    end else if (ld_en) begin
      data_d  = ld_data;
      valid_d = '1;
    end else if (wr_en) begin
      for (int i = 0; i < WORDS; i++) begin
        if (wr_addr == AW'(i)) begin
          data_d[i*WORD_W +: WORD_W] = wr_data;
          valid_d[i]                 = 1'b1;
        end
      end
    end
    for (int i = 0; i < WORDS; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data_d = data_q[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= '0;
      rd_data_q <= '0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lowmc_key_ctrl.sv
// rtl/lowmc_key_ctrl.sv - assembles key/plaintext words, launches one LowMC job and captures the ciphertext
module lowmc_key_ctrl
  import lowmc_ctrl_pkg::*;
#(
  parameter int N     = 128,
  parameter int CNT_W = 16
) (
  input  logic                                Clk_CI,
  input  logic                                Rst_RI,
  input  logic                                RegWrEn_SI,
  input  logic [addr_w(2*words_of(N))-1:0]    RegWrAddr_DI,
  input  logic [WORD_W-1:0]                   RegWrData_DI,
  input  logic                                Cmd_SI,
  input  logic                                Clear_SI,
  input  logic [addr_w(words_of(N))-1:0]      RegRdAddr_DI,
  output logic [WORD_W-1:0]                   RegRdData_DO,
  output logic                                Busy_SO,
  output logic                                Done_SO,
  output logic                                Err_SO,
  output logic [CNT_W-1:0]                    Cycles_DO,
  lowmc_key_ctrl_if.master                    core_if
);

  localparam int NW    = words_of(N);
  localparam int WR_AW = addr_w(2 * NW);
  localparam int RD_AW = addr_w(NW);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             kp_wr_en, kp_clr, ct_ld, core_start;
  logic [2*N-1:0]   kp_data;
  logic [2*NW-1:0]  kp_valid;
  logic [NW-1:0]    key_valid;
  logic [WORD_W-1:0] kp_rd_data;
  logic [N-1:0]     ct_data;
  logic [NW-1:0]    ct_valid;

  // Key occupies the low N/32 words, plaintext the high N/32 words.
  lowmc_word_regfile #(
    .WORDS (2 * NW),
    .AW    (WR_AW)
  ) u_kp_regs (
    .clk       (Clk_CI),
    .rst       (Rst_RI),
    .wr_en     (kp_wr_en),
    .wr_addr   (RegWrAddr_DI),
    .wr_data   (RegWrData_DI),
    .ld_en     (1'b0),
    .ld_data   ({(2*N){1'b0}}),
    .clr_valid (kp_clr),
    .rd_addr   ({WR_AW{1'b0}}),
    .data_o    (kp_data),
    .valid_o   (kp_valid),
    .rd_data_o (kp_rd_data)
  );

  lowmc_word_regfile #(
    .WORDS (NW),
    .AW    (RD_AW)
  ) u_ct_regs (
    .clk       (Clk_CI),
    .rst       (Rst_RI),
    .wr_en     (1'b0),
    .wr_addr   ({RD_AW{1'b0}}),
    .wr_data   ({WORD_W{1'b0}}),
    .ld_en     (ct_ld),
    .ld_data   (core_if.CoreCipher_DI),
    .clr_valid (1'b0),
    .rd_addr   (RegRdAddr_DI),
    .data_o    (ct_data),
    .valid_o   (ct_valid),
    .rd_data_o (RegRdData_DO)
  );

  assign key_valid = kp_valid[NW-1:0];

  logic unused_bits;
  assign unused_bits = ^{kp_rd_data, kp_valid[2*NW-1:NW], ct_data, ct_valid};

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // In IDLE: clear beats command beats write; the command sees the pre-write mask.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Clear_SI) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end else if (Cmd_SI) begin
          if (&key_valid) begin
            state_d = ST_LAUNCH;
            done_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (core_if.CoreFinish_SI) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cycles_d = cnt_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && (RegWrEn_SI || Cmd_SI)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    kp_wr_en   = 1'b0;
    kp_clr     = 1'b0;
    ct_ld      = 1'b0;
    Busy_SO    = (state_q != ST_IDLE);
    core_start = (state_q == ST_LAUNCH);
    if (state_q == ST_IDLE) begin
      kp_clr   = Clear_SI;
      kp_wr_en = RegWrEn_SI && !Clear_SI;
    end
    if (state_q == ST_WAIT) begin
      ct_ld = core_if.CoreFinish_SI;
    end
  end

  assign core_if.CoreKey_DO   = kp_data[N-1:0];
  assign core_if.CorePlain_DO = kp_data[2*N-1:N];
  assign core_if.CoreStart_SO = core_start;
  assign Done_SO              = done_q;
  assign Err_SO               = err_q;
  assign Cycles_DO            = cycles_q;

endmodule

// File: tb/tb_lowmc_key_ctrl.sv
// tb/tb_lowmc_key_ctrl.sv - directed bench for lowmc_key_ctrl at CNT_W=16 and CNT_W=4
module tb_lowmc_key_ctrl;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, cmd, clear;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_addr;

  logic [31:0] rd_a, rd_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [15:0] cyc_a;
  logic [3:0]  cyc_b;

  int n_chk = 0;
  int n_err = 0;
  int starts_a = 0;
  int starts_b = 0;

  always #5 clk = ~clk;

  lowmc_key_ctrl_if #(.N(N)) if_a ();
  lowmc_key_ctrl_if #(.N(N)) if_b ();

  lowmc_key_ctrl #(.N(N), .CNT_W(16)) dut_a (
    .Clk_CI(clk), .Rst_RI(rst), .RegWrEn_SI(wr_en), .RegWrAddr_DI(wr_addr),
    .RegWrData_DI(wr_data), .Cmd_SI(cmd), .Clear_SI(clear), .RegRdAddr_DI(rd_addr),
    .RegRdData_DO(rd_a), .Busy_SO(busy_a), .Done_SO(done_a), .Err_SO(err_a),
    .Cycles_DO(cyc_a), .core_if(if_a)
  );

  lowmc_key_ctrl #(.N(N), .CNT_W(4)) dut_b (
    .Clk_CI(clk), .Rst_RI(rst), .RegWrEn_SI(wr_en), .RegWrAddr_DI(wr_addr),
    .RegWrData_DI(wr_data), .Cmd_SI(cmd), .Clear_SI(clear), .RegRdAddr_DI(rd_addr),
    .RegRdData_DO(rd_b), .Busy_SO(busy_b), .Done_SO(done_b), .Err_SO(err_b),
    .Cycles_DO(cyc_b), .core_if(if_b)
  );

  always @(negedge clk) begin
    if (if_a.CoreStart_SO) starts_a++;
    if (if_b.CoreStart_SO) starts_b++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_finish(input logic f, input logic [127:0] c);
    if_a.CoreFinish_SI = f;
    if_b.CoreFinish_SI = f;
    if_a.CoreCipher_DI = c;
    if_b.CoreCipher_DI = c;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_cmd();
    cmd = 1'b1;
    @(negedge clk);
    cmd = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic core_run(input int waits, input logic [127:0] c);
    repeat (waits) @(negedge clk);
    set_finish(1'b1, c);
    @(negedge clk);
    set_finish(1'b0, '0);
    check("capture_busy", busy_a, 1);
    check("capture_done", done_a, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; cmd = 1'b0; clear = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    set_finish(1'b0, '0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_start", if_a.CoreStart_SO, 0);
    check("rst_cycles", cyc_a, 0);
    check("rst_rdata", rd_a, 0);
    check("rst_key", if_a.CoreKey_DO, 0);
    rst = 1'b0;

    // Job 1: key 1..4, plaintext 0, core answers on the 10th WAIT cycle.
    for (int i = 0; i < 4; i++) reg_write(3'(i), 32'(i + 1));
    for (int i = 4; i < 8; i++) reg_write(3'(i), 32'h0);
    check("key_asm", if_a.CoreKey_DO, 128'h00000004_00000003_00000002_00000001);
    check("plain_zero", if_a.CorePlain_DO, 0);
    pulse_cmd();
    check("j1_start", if_a.CoreStart_SO, 1);
    check("j1_busy", busy_a, 1);
    core_run(10, 128'h44444444_DEADBEEF_22222222_11111111);
    check("j1_done", done_a, 1);
    check("j1_busy_end", busy_a, 0);
    check("j1_cycles_a", cyc_a, 10);
    check("j1_cycles_b", cyc_b, 10);
    check("j1_starts", starts_a, 1);
    check("j1_err", err_a, 0);
    rd_addr = 2'd2;
    #1;
    check("rd_latency", rd_a, 32'h11111111);
    @(negedge clk);
    check("rd_word2_a", rd_a, 32'hDEADBEEF);
    check("rd_word2_b", rd_b, 32'hDEADBEEF);

    // Finish pulse in IDLE must not touch the ciphertext.
    set_finish(1'b1, {4{32'h5A5A5A5A}});
    @(negedge clk);
    set_finish(1'b0, '0);
    @(negedge clk);
    check("idle_finish", rd_a, 32'hDEADBEEF);
    check("idle_finish_busy", busy_a, 0);

    // Job 2: incomplete key mask.
    pulse_clear();
    check("clr_done", done_a, 0);
    for (int i = 0; i < 3; i++) reg_write(3'(i), 32'(i + 5));
    pulse_cmd();
    check("nokey_start", if_a.CoreStart_SO, 0);
    check("nokey_busy", busy_a, 0);
    check("nokey_err", err_a, 1);
    cmd = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'd8;
    @(negedge clk);
    cmd = 1'b0; wr_en = 1'b0;
    check("cmdwr_busy", busy_a, 0);
    check("cmdwr_word3", if_a.CoreKey_DO[127:96], 32'd8);
    check("cmdwr_starts", starts_a, 1);
    pulse_clear();
    check("clr_err", err_a, 0);
    check("clr_err_b", err_b, 0);

    // Job 3: illegal traffic during WAIT, core takes 20 cycles.
    for (int i = 0; i < 4; i++) reg_write(3'(i), 32'(i + 5));
    reg_write(3'd4, 32'hAAAA0000);
    pulse_cmd();
    check("j3_start", if_a.CoreStart_SO, 1);
    @(negedge clk);
    cmd = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFFFFFF;
    @(negedge clk);
    cmd = 1'b0; wr_en = 1'b0;
    pulse_clear();
    check("busy_key_hold", if_a.CoreKey_DO, 128'h00000008_00000007_00000006_00000005);
    check("busy_err", err_a, 1);
    check("busy_still", busy_a, 1);
    core_run(17, 128'h0);
    check("j3_cycles_a", cyc_a, 20);
    check("j3_cycles_sat", cyc_b, 15);
    check("j3_starts_a", starts_a, 2);
    check("j3_starts_b", starts_b, 2);
    check("j3_done", done_a, 1);
    check("j3_err_sticky", err_a, 1);
    check("j3_plain", if_a.CorePlain_DO, 128'h0000AAAA0000);

    // Job 4: reset while waiting, then a stale finish.
    pulse_cmd();
    check("j4_start", if_a.CoreStart_SO, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy_a, 0);
    set_finish(1'b1, {4{32'h12345678}});
    @(negedge clk);
    set_finish(1'b0, '0);
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy_a, 0);
    check("post_rst_done", done_a, 0);
    check("post_rst_done_b", done_b, 0);
    check("post_rst_err", err_a, 0);
    check("post_rst_cycles", cyc_a, 0);
    check("post_rst_rdata", rd_a, 0);
    check("post_rst_key", if_a.CoreKey_DO, 0);
    check("post_rst_plain", if_a.CorePlain_DO, 0);
    pulse_cmd();
    check("post_rst_cmd_err", err_a, 1);
    check("post_rst_cmd_busy", busy_a, 0);
    @(negedge clk);
    check("total_starts", starts_a, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lowmc_key_ctrl.md
# lowmc_key_ctrl

Job controller between the AXI-lite key/plaintext register bank and the LowMC encryption core. Assembles 32-bit register writes into 128-bit key and plaintext vectors and tracks which key words have been written. On command it launches one core encryption, captures the ciphertext and counts the elapsed cycles. It sits directly behind the AXI-lite slave logic in the Kintex7 coprocessor and exposes busy, done and error status back to it.

## Interface
Parameters:
- `N` — default 128 — LowMC block/key width in bits; must be a multiple of 32.
- `CNT_W` — default 16 — width of the encryption cycle counter.

Ports:
- `Clk_CI` — in — 1 — the single clock.
- `Rst_RI` — in — 1 — synchronous, active-high reset.
- `RegWrEn_SI` — in — 1 — register write strobe, one word per cycle.
- `RegWrAddr_DI` — in — clog2(2N/32) — word 0..N/32-1 selects key, N/32..2N/32-1 selects plaintext; word 0 = bits [31:0].
- `RegWrData_DI` — in — 32 — write data.
- `Cmd_SI` — in — 1 — start pulse.
- `Clear_SI` — in — 1 — clears done, error and key-valid mask.
- `RegRdAddr_DI` — in — clog2(N/32) — ciphertext word select.
- `RegRdData_DO` — out — 32 — selected ciphertext word, registered.
- `Busy_SO` — out — 1 — a job is in flight.
- `Done_SO` — out — 1 — sticky; a job has completed.
- `Err_SO` — out — 1 — sticky; an illegal command or write occurred.
- `Cycles_DO` — out — CNT_W — cycles of the last job, saturating.
- `CoreKey_DO` — out — N — key to the core, held stable while busy.
- `CorePlain_DO` — out — N — plaintext to the core, held stable while busy.
- `CoreStart_SO` — out — 1 — one-cycle start pulse to the core.
- `CoreFinish_SI` — in — 1 — core completion pulse.
- `CoreCipher_DI` — in — N — core result, valid in the cycle `CoreFinish_SI` is high.

## Operation
- State machine: IDLE → LAUNCH → WAIT → CAPTURE → IDLE.
- IDLE:
  - A write updates the addressed word.
  - A key-word write also sets that word's bit in `KeyValid[N/32-1:0]`.
- `Cmd_SI` in IDLE:
  - If `KeyValid` is all ones: go to LAUNCH, clear `Done_SO`, zero the cycle counter.
  - Otherwise: set `Err_SO` and stay in IDLE.
- LAUNCH: `CoreStart_SO`=1 for exactly this cycle; go to WAIT.
- WAIT:
  - The counter increments every cycle and saturates at all-ones.
  - On `CoreFinish_SI`, latch `CoreCipher_DI` into the ciphertext register and go to CAPTURE.
- CAPTURE: copy the counter to `Cycles_DO`, set `Done_SO`, return to IDLE.
- `Busy_SO`=1 in LAUNCH, WAIT and CAPTURE.
- While busy, `RegWrEn_SI` or `Cmd_SI` is ignored (no data change) and sets `Err_SO`.
- `CoreFinish_SI` outside WAIT is ignored.
- `Clear_SI` in IDLE clears `Done_SO`, `Err_SO` and `KeyValid`. Key, plaintext and ciphertext data are retained.
- `Clear_SI` while busy is ignored.
- Simultaneous events in IDLE, by priority: `Clear_SI` > `Cmd_SI` > write.
  - Clear with Cmd: clear wins and no start (`KeyValid` is now 0).
  - Cmd with write: the command evaluates the pre-write `KeyValid`; the write still lands.
- `KeyValid` persists across jobs. The same key may be reused with new plaintexts.

## Timing
- Reset values:
  - state IDLE
  - all data registers 0
  - `KeyValid`=0
  - `Busy_SO`, `Done_SO`, `Err_SO`, `CoreStart_SO` = 0
  - `Cycles_DO`=0
  - `RegRdData_DO`=0
- Reset mid-job: returns to IDLE in the next cycle. A later `CoreFinish_SI` is ignored.
- `Cmd_SI` at edge t → `Busy_SO`=1 and `CoreStart_SO`=1 at t+1.
- `CoreFinish_SI` at edge f → `Done_SO`=1, `Busy_SO`=0 and `Cycles_DO` valid at f+2. `Cycles_DO` = number of WAIT cycles including f.
- `RegRdData_DO`: one-cycle read latency from `RegRdAddr_DI`.
- A write at edge w is visible on `CoreKey_DO`/`CorePlain_DO` at w+1.

## Structure
- Shared package `lowmc_ctrl_pkg`: `N`-dependent constants (`WORDS`=N/32, address widths) and the state enum `ctrl_state_t`.
- Sub-module `lowmc_word_regfile`: word-addressed write port with valid mask and a registered read mux. It is instantiated for key/plaintext storage and for the ciphertext read-out.

## Test plan
- Write key words 0–3 = 1,2,3,4 and plaintext = 0; Cmd; core model finishes after 10 cycles → `CoreStart_SO` one pulse; `CoreKey_DO`=0x00000004_00000003_00000002_00000001; `Done_SO`=1; `Cycles_DO`=10.
- Write only key words 0–2; Cmd → no `CoreStart_SO`; `Err_SO`=1; `Busy_SO` stays 0. Then Clear → `Err_SO`=0.
- During WAIT, write key word 0 = 0xFFFFFFFF and pulse Cmd → key unchanged; exactly one core start total; `Err_SO`=1.
- Finish with cipher word2=0xDEADBEEF; read addr 2 → `RegRdData_DO`=0xDEADBEEF one cycle later.
- `CNT_W`=4, core takes 20 cycles → `Cycles_DO`=15 (saturated).
- Assert `Rst_RI` in WAIT, then pulse `CoreFinish_SI` → all outputs at reset values; `Done_SO` stays 0.
